muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations for the rv32im core. It sits beside the single-cycle ALU in the execute stage. The core's control path raises `start` when an M-extension instruction reaches execute, then stalls until `done`. It uses one shared 64-bit shift/accumulate datapath for both operations, with fixed latency for every operation.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings, FSM states and constants for the RV32M
// iterative multiply/divide unit.

package muldiv_pkg;

   // funct3 encodings of the M-extension operations
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   // Results forced for the architecturally defined corner cases
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   // funct3[2] separates divide/remainder from multiply
   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
   function automatic logic op_signed_a(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed for MUL, MULH, DIV, REM
   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage : muldiv_pkg

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of the shared 64-bit datapath.
//   multiply: shift-add, multiplier in acc[31:0], partial product grows in
//             the upper half and everything shifts right by one.
//   divide:   restoring step, dividend bits shift out of acc[31:0] into the
//             partial remainder in the upper half; quotient bits shift in at
//             acc[0].

module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   input  logic              is_div_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_rem;
   logic            div_ge;
   logic [XLEN-1:0] div_upper;

   // Single iteration: add-and-shift-right for multiply, trial subtract and
   // shift-left for divide
   always_comb begin
      mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      // partial remainder shifted left with the next dividend bit appended
      div_rem   = acc_i[2*XLEN-1:XLEN-1];
      div_ge    = (div_rem >= {1'b0, opnd_i});
      // when the subtract succeeds the difference is below the divisor, so
      // the low XLEN bits hold it exactly
      div_upper = div_ge ? (div_rem[XLEN-1:0] - opnd_i) : div_rem[XLEN-1:0];
      if (is_div_i) begin
         acc_o = {div_upper, acc_i[XLEN-2:0], div_ge};
      end else begin
         acc_o = {mul_sum, acc_i[XLEN-1:1]};
      end
   end

endmodule : muldiv_step

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with a fixed 33-cycle latency.
//
// Handshake: when busy=0 the unit samples start (with op/a/b) on a rising
// edge and accepts it unless flush is also high; busy is then high for 32
// cycles, followed by a single-cycle done pulse with result valid. start is
// accepted again in the done cycle for back-to-back operation. start while
// busy=1 is ignored. flush cancels anything in flight without a done pulse.

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output muldiv_state_e   dbg_state_o
);

   localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

   muldiv_state_e     state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [2*XLEN-1:0] acc_nxt;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;
   logic              div_ovf;
   logic [XLEN-1:0]   final_res;
   logic              accept;

   // Operand signs and magnitudes from the live inputs, used only on accept
   always_comb begin
      sign_a = op_signed_a(op) & a[XLEN-1];
      sign_b = op_signed_b(op) & b[XLEN-1];
      mag_a  = sign_a ? -a : a;
      mag_b  = sign_b ? -b : b;
   end

   muldiv_step #(
      .XLEN (XLEN)
   ) u_step (
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .is_div_i (op_is_div(op_q)),
      .acc_o    (acc_nxt)
   );

   // Sign fix-up and corner-case override applied to the last iteration's
   // output, so the result register loads on the edge into DONE
   always_comb begin
      prod_s  = neg_res_q ? -acc_nxt : acc_nxt;
      quo_s   = neg_res_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      rem_s   = neg_rem_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      div_ovf = (a_q == INT_MIN) && (b_q == '1);
      final_res = '0;
      case (op_q)
         OP_MUL:                        final_res = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
         OP_DIV: begin
            if (b_q == '0)   final_res = DIV_BY_ZERO_Q;
            else if (div_ovf) final_res = INT_MIN;
            else              final_res = quo_s;
         end
         OP_DIVU:           final_res = (b_q == '0) ? DIV_BY_ZERO_Q : quo_s;
         OP_REM: begin
            if (b_q == '0)    final_res = a_q;
            else if (div_ovf) final_res = '0;
            else              final_res = rem_s;
         end
         OP_REMU:           final_res = (b_q == '0) ? a_q : rem_s;
         default:           final_res = '0;
      endcase
   end

   // Next-state logic: flush wins, otherwise IDLE/DONE may accept and CALC
   // iterates until the last count
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      accept    = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: accept = start;
            CALC: begin
               acc_d = acc_nxt;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) begin
                  state_d  = DONE;
                  result_d = final_res;
               end
            end
            DONE: begin
               state_d = IDLE;
               accept  = start;
            end
            default: state_d = IDLE;
         endcase
      end
      if (accept) begin
         state_d   = CALC;
         cnt_d     = '0;
         op_d      = op;
         a_d       = a;
         b_d       = b;
         acc_d     = {{XLEN{1'b0}}, mag_a};
         opnd_d    = mag_b;
         neg_res_d = sign_a ^ sign_b;
         neg_rem_d = sign_a;
      end
   end

   // State, counter, latched operands and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign result      = result_q;
   assign dbg_state_o = state_q;

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an
// arithmetic reference model.

module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          flush;
   logic [2:0]    op;
   logic [31:0]   a;
   logic [31:0]   b;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   muldiv_state_e dbg_state;

   int            n_checks;
   int            n_fail;
   logic [31:0]   exp_q[$];
   logic [31:0]   last_res;

   muldiv_unit #(
      .XLEN (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .flush       (flush),
      .op          (op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // reference model: RV32M semantics with 64-bit arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
      longint sx, sy, ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      p  = 0;
      case (o)
         3'b000: begin p = sx * sy; return p[31:0];  end
         3'b001: begin p = sx * sy; return p[63:32]; end
         3'b010: begin p = sx * uy; return p[63:32]; end
         3'b011: begin p = ux * uy; return p[63:32]; end
         3'b100: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sx / sy; return p[31:0];
         end
         3'b101: begin
            if (y == 0) return 32'hFFFF_FFFF;
            p = ux / uy; return p[31:0];
         end
         3'b110: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            p = sx % sy; return p[31:0];
         end
         default: begin
            if (y == 0) return x;
            p = ux % uy; return p[31:0];
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // driver: present an operation for one edge; returns in cycle 1
   task automatic accept(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      exp_q.push_back(ref_model(o, x, y));
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   // wait for done (called in cycle 1); optional ignored start at poke_cyc,
   // optional back-to-back accept in the done cycle
   task automatic wait_done(input string tag, input int poke_cyc, input bit chain,
                            input logic [2:0] nop, input logic [31:0] na,
                            input logic [31:0] nb);
      int          cyc;
      logic [31:0] exp;
      cyc = 1;
      check_eq({tag, "_busy_c1"}, 32'(busy), 32'd1);
      check_eq({tag, "_state_c1"}, 32'(dbg_state), 32'(CALC));
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == poke_cyc + 1) start = 1'b0;
         if (cyc == poke_cyc) begin
            start = 1'b1;
            op    = 3'($urandom);
            a     = $urandom;
            b     = $urandom;
         end
         if (cyc == 32) check_eq({tag, "_busy_c32"}, 32'(busy), 32'd1);
      end
      if (done) begin
         check_eq({tag, "_done_cycle"}, 32'(cyc), 32'd33);
         check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
         if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
         end else begin
            exp = exp_q.pop_front();
            check_eq({tag, "_result"}, result, exp);
            last_res = exp;
         end
         if (chain) accept(nop, na, nb);
      end else begin
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
      accept(o, x, y);
      wait_done(tag, -1, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   typedef struct {
      logic [2:0]  o;
      logic [31:0] x;
      logic [31:0] y;
   } vec_t;

   vec_t dir_v[13];
   int   n_done;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      last_res = 32'd0;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'd0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_result", result, 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors, including the corner cases
      dir_v[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD};
      dir_v[1]  = '{OP_MULHU,  32'd7,          32'hFFFF_FFFD};
      dir_v[2]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000};
      dir_v[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
      dir_v[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2};
      dir_v[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2};
      dir_v[6]  = '{OP_DIVU,   32'd100,        32'd7};
      dir_v[7]  = '{OP_REMU,   32'd100,        32'd7};
      dir_v[8]  = '{OP_DIVU,   32'd5,          32'd0};
      dir_v[9]  = '{OP_REM,    32'd5,          32'd0};
      dir_v[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF};
      dir_v[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF};
      dir_v[12] = '{OP_DIV,    32'hFFFF_FFF9,  32'd0};
      foreach (dir_v[i]) run_op($sformatf("dir%0d", i), dir_v[i].o, dir_v[i].x, dir_v[i].y);

      // a few results spelled out as literal constants
      run_op("mul_lit", OP_MUL, 32'd7, 32'hFFFF_FFFD);
      check_eq("mul_lit_const", result, 32'hFFFF_FFEB);
      run_op("divu_lit", OP_DIVU, 32'd100, 32'd7);
      check_eq("divu_lit_const", result, 32'd14);

      // randomized operations
      for (int i = 0; i < 60; i++) begin
         run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      end

      // start while busy is ignored
      accept(OP_DIV, 32'hFFFF_FF00, 32'd9);
      wait_done("busy_start", 10, 1'b0, 3'd0, 32'd0, 32'd0);
      check_eq("busy_start_idle", 32'(dbg_state), 32'(DONE));

      // back-to-back start in the done cycle: second done 66 cycles after the first start
      accept(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
      wait_done("b2b_first", -1, 1'b1, OP_REMU, 32'hCAFE_F00D, 32'd1000);
      wait_done("b2b_second", -1, 1'b0, 3'd0, 32'd0, 32'd0);

      // flush in cycle 15
      @(posedge clk);
      #1;
      accept(OP_MUL, 32'd12345, 32'd678);
      void'(exp_q.pop_back());
      repeat (14) begin
         @(posedge clk);
         #1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("flush_state", 32'(dbg_state), 32'(IDLE));
      check_eq("flush_busy", 32'(busy), 32'd0);
      check_eq("flush_result_kept", result, last_res);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check_eq("flush_no_done", 32'(n_done), 32'd0);

      // asynchronous reset in cycle 20
      accept(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
      void'(exp_q.pop_back());
      repeat (19) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_done", 32'(done), 32'd0);
      check_eq("arst_result", result, 32'd0);
      check_eq("arst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      last_res = 32'd0;
      @(posedge clk);
      #1;
      run_op("after_rst", OP_MULH, 32'h7FFF_FFFF, 32'h8000_0000);

      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // hard watchdog against a hung run
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_muldiv_unit
